// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: shared defaults and read-controller state encoding for the syn_fifo family
package syn_fifo_pkg;
    localparam int FIFO_ENTRIES_DEF = 16;
    localparam int DATA_WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/syn_fifo_skid_buf.sv
// syn_fifo_skid_buf: 2-entry in-order output buffer, head entry always presented on data_o
module syn_fifo_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] e1;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
            e1 <= '0;
            count_o <= '0;
        end else begin
            count_o <= count_o + {1'b0, push_i} - {1'b0, pop_i};
            if (pop_i && count_o == 2'd2)
                data_o <= e1;
            else if (push_i && (pop_i || count_o == 2'd0))
                data_o <= data_i;
            if (push_i && (pop_i ? count_o == 2'd2 : count_o == 2'd1))
                e1 <= data_i;
        end
    end
endmodule

// File: rtl/syn_fifo_rd_ctrl.sv
// syn_fifo_rd_ctrl: drains a burst from a registered-empty FIFO into a valid/ready stream
module syn_fifo_rd_ctrl
    import syn_fifo_pkg::*;
#(
    parameter int FIFO_ENTRIES = FIFO_ENTRIES_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [$clog2(FIFO_ENTRIES):0]   burst_len_i,
    output logic                            busy_o,
    output logic                            done_o,
    input  logic                            fifo_empty_i,
    output logic                            fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0]           fifo_data_i,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    output logic                            m_last_o,
    output logic [$clog2(FIFO_ENTRIES):0]   words_left_o
);
    localparam int CW = $clog2(FIFO_ENTRIES) + 1;
    rd_state_t state, state_nxt;
    logic [CW-1:0] issue_cnt, out_cnt;
    logic inflight, inflight_last, pop, last_issue, last_pop;
    logic [1:0] buf_cnt;
    logic [DATA_WIDTH:0] buf_q;
    assign m_valid_o = buf_cnt != 2'd0;
    assign pop = m_valid_o & m_ready_i;
    // buffered + in-flight words after this cycle's pop must leave room for one more
    assign fifo_rd_en_o = !rst_i && state == READ && issue_cnt != '0 && !fifo_empty_i &&
                          ({1'b0, buf_cnt} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    assign last_issue = fifo_rd_en_o && issue_cnt == CW'(1);
    assign last_pop = pop && out_cnt == CW'(1);
    assign m_data_o = buf_q[DATA_WIDTH-1:0];
    assign m_last_o = m_valid_o & buf_q[DATA_WIDTH];
    assign busy_o = state != IDLE;
    assign done_o = state == DONE;
    assign words_left_o = out_cnt;
    always_comb begin
        state_nxt = state == IDLE  ? ((start_i && burst_len_i != '0) ? READ : IDLE) :
                    state == READ  ? (last_issue ? DRAIN : READ) :
                    state == DRAIN ? (last_pop ? DONE : DRAIN) : IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            issue_cnt <= '0;
            out_cnt <= '0;
            inflight <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state <= state_nxt;
            inflight <= fifo_rd_en_o;
            inflight_last <= last_issue;
            if (fifo_rd_en_o)
                issue_cnt <= issue_cnt - CW'(1);
            if (pop)
                out_cnt <= out_cnt - CW'(1);
            if (state == IDLE && state_nxt == READ) begin
                issue_cnt <= burst_len_i;
                out_cnt <= burst_len_i;
            end
        end
    end
    syn_fifo_skid_buf #(.W(DATA_WIDTH + 1)) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight),
        .data_i  ({inflight_last, fifo_data_i}),
        .pop_i   (pop),
        .data_o  (buf_q),
        .count_o (buf_cnt)
    );
endmodule

// File: tb/tb_syn_fifo_rd_ctrl.sv
// tb_syn_fifo_rd_ctrl: randomized scoreboard bench with a behavioural FIFO and word-stream model
module tb_syn_fifo_rd_ctrl;
    localparam int N = 16;
    localparam int DW = 8;
    localparam int CW = $clog2(N) + 1;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic [CW-1:0] burst_len_i = '0;
    logic fifo_empty_i = 1'b1;
    logic [DW-1:0] fifo_data_i = '0;
    logic m_ready_i = 1'b0;
    logic busy_o, done_o, fifo_rd_en_o, m_valid_o, m_last_o;
    logic [DW-1:0] m_data_o;
    logic [CW-1:0] words_left_o;
    int checks = 0;
    int fails = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_words[$];
    int pending[$];
    int rem = 0;
    int ready_mode = 0;
    logic fifo_full = 1'b0;
    logic pop_req = 1'b0;
    logic held = 1'b0;
    logic prev_last = 1'b0;
    logic held_last = 1'b0;
    logic [DW-1:0] held_data = '0;
    always #5 clk = ~clk;
    syn_fifo_rd_ctrl #(.FIFO_ENTRIES(N), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .burst_len_i  (burst_len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_data_i  (fifo_data_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o),
        .words_left_o (words_left_o)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // FIFO model: pop request sampled mid-cycle, data and flags registered on the edge
    always @(negedge clk) pop_req = fifo_rd_en_o;
    always @(posedge clk) begin
        if (pop_req) begin
            check("rd_en_nonempty", 32'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) fifo_data_i <= fifo_q.pop_front();
        end
        fifo_empty_i <= fifo_q.size() == 0;
        fifo_full <= fifo_q.size() == N;
    end
    initial forever begin
        @(posedge clk);
        #1;
        m_ready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~m_ready_i : 1'($urandom_range(0, 1));
    end
    // monitor: every accepted word is checked against the pushed-word stream and burst lengths
    always @(negedge clk) begin
        if (rst_i) begin
            held = 1'b0;
            prev_last = 1'b0;
        end else begin
            check("done_pulse", 32'(done_o), 32'(prev_last));
            if (held) begin
                check("stall_valid", 32'(m_valid_o), 1);
                check("stall_data", 32'(m_data_o), 32'(held_data));
                check("stall_last", 32'(m_last_o), 32'(held_last));
            end
            held = m_valid_o && !m_ready_i;
            held_data = m_data_o;
            held_last = m_last_o;
            prev_last = 1'b0;
            if (m_valid_o && m_ready_i) begin
                if (rem == 0 && pending.size() != 0) rem = pending.pop_front();
                if (rem == 0 || sb_words.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected no word", m_data_o);
                end else begin
                    check("data", 32'(m_data_o), 32'(sb_words.pop_front()));
                    check("last", 32'(m_last_o), 32'(rem == 1));
                    check("words_left", 32'(words_left_o), 32'(rem));
                    prev_last = rem == 1;
                    rem--;
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        sb_words.push_back(w);
    endtask
    task automatic start(input int len, input bit accept);
        start_i = 1'b1;
        burst_len_i = CW'(len);
        if (accept) pending.push_back(len);
        tick();
        start_i = 1'b0;
    endtask
    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy_o), 0);
        tick();
        check("burst_consumed", 32'(pending.size() + rem), 0);
    endtask
    task automatic wait_rd_en(output int n);
        n = 0;
        @(negedge clk);
        while (!fifo_rd_en_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_en_seen", 32'(n < 20), 1);
    endtask
    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en_o), 0);
        check({tag, "_valid"}, 32'(m_valid_o), 0);
        check({tag, "_last"}, 32'(m_last_o), 0);
        check({tag, "_data"}, 32'(m_data_o), 0);
        check({tag, "_words_left"}, 32'(words_left_o), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        int n, len, k;
        repeat (3) tick();
        @(negedge clk);
        check_outputs_zero("in_reset");
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset");
        tick();
        // full-rate burst of 16 ordered words
        ready_mode = 0;
        for (int i = 1; i <= 16; i++) push(DW'(i));
        tick();
        tick();
        check("fifo_full_before", 32'(fifo_full), 1);
        start(16, 1);
        wait_rd_en(n);
        @(negedge clk);
        check("full_falls", 32'(fifo_full), 0);
        check("valid_lat1", 32'(m_valid_o), 0);
        @(negedge clk);
        check("valid_lat2", 32'(m_valid_o), 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("back_to_back", 32'(m_valid_o && m_ready_i), 1);
        end
        wait_idle(40);
        check("fifo_drained", 32'(fifo_q.size()), 0);
        check("fifo_empty_flag", 32'(fifo_empty_i), 1);
        // alternating backpressure
        ready_mode = 1;
        for (int i = 0; i < 8; i++) push(DW'($urandom));
        tick();
        tick();
        start(8, 1);
        wait_idle(60);
        // FIFO runs dry mid-burst, then refills
        ready_mode = 0;
        push(8'h21);
        push(8'h22);
        tick();
        tick();
        start(5, 1);
        repeat (10) tick();
        check("stall_busy", 32'(busy_o), 1);
        check("stall_valid_low", 32'(m_valid_o), 0);
        check("stall_words_left", 32'(words_left_o), 3);
        push(8'h23);
        push(8'h24);
        push(8'h25);
        wait_idle(40);
        check("words_left_idle", 32'(words_left_o), 0);
        // zero-length start and starts while busy are ignored
        start(0, 0);
        repeat (4) begin
            @(negedge clk);
            check("len0_rd_en", 32'(fifo_rd_en_o), 0);
            check("len0_busy", 32'(busy_o), 0);
        end
        tick();
        ready_mode = 2;
        for (int i = 0; i < 6; i++) push(DW'($urandom));
        tick();
        tick();
        start(6, 1);
        repeat (3) start(3, 0);
        wait_idle(80);
        check("no_extra_pop", 32'(fifo_q.size()), 0);
        // random bursts with split pushes and random backpressure
        repeat (6) begin
            len = $urandom_range(1, 16);
            k = $urandom_range(0, len);
            ready_mode = $urandom_range(0, 1) * 2;
            for (int i = 0; i < k; i++) push(DW'($urandom));
            tick();
            start(len, 1);
            repeat ($urandom_range(0, 8)) tick();
            for (int i = k; i < len; i++) push(DW'($urandom));
            wait_idle(200);
        end
        // reset in the middle of a burst discards everything in flight
        ready_mode = 0;
        for (int i = 0; i < 16; i++) push(DW'(8'h40 + i));
        tick();
        tick();
        start(16, 1);
        n = 0;
        while (!m_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_valid_seen", 32'(n < 20), 1);
        repeat (3) tick();
        rst_i = 1'b1;
        fifo_q.delete();
        sb_words.delete();
        pending.delete();
        rem = 0;
        @(negedge clk);
        check("reset_rd_en_gated", 32'(fifo_rd_en_o), 0);
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        tick();
        for (int i = 0; i < 4; i++) push(DW'(8'hC0 + i));
        tick();
        tick();
        start(4, 1);
        wait_idle(40);
        check("post_reset_drained", 32'(fifo_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end
endmodule

// File: doc/syn_fifo_rd_ctrl.md
SYN_FIFO_RD_CTRL -- requirements
Module: syn_fifo_rd_ctrl

Interface
REQ-001 Parameter FIFO_ENTRIES, default 16, depth of the attached syn_fifo; max burst length.
REQ-002 Parameter DATA_WIDTH, default 8, word width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk_i  input  1  system clock; all state changes on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  burst request; sampled only in IDLE.
REQ-007 burst_len_i  input  $clog2(FIFO_ENTRIES)+1  words to drain, 1..FIFO_ENTRIES.
REQ-008 busy_o  output  1  high in every state except IDLE.
REQ-009 done_o  output  1  one-cycle pulse on burst completion.
REQ-010 fifo_empty_i  input  1  FIFO empty flag; registered, reflects pops up to the previous edge.
REQ-011 fifo_rd_en_o  output  1  FIFO pop strobe.
REQ-012 fifo_data_i  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en_o.
REQ-013 m_valid_o / m_ready_i / m_data_o  out/in/out  1/1/DATA_WIDTH  output stream handshake.
REQ-014 m_last_o  output  1  marks the final word of the burst; qualified by m_valid_o.
REQ-015 words_left_o  output  $clog2(FIFO_ENTRIES)+1  words of the burst not yet accepted downstream.

Function
REQ-016 FSM states: IDLE, READ, DRAIN, DONE.
REQ-017 IDLE -> READ when start_i=1 and burst_len_i!=0; latch issue_cnt and out_cnt = burst_len_i.
REQ-018 start_i with burst_len_i=0, or any start_i outside IDLE, SHALL be ignored with no side effects.
REQ-019 Occupancy rule: fifo_rd_en_o=1 only in READ, when issue_cnt>0, fifo_empty_i=0, and (buf_cnt + inflight - pop) < 2, where pop = m_valid_o & m_ready_i.
REQ-020 Each fifo_rd_en_o decrements issue_cnt; issue_cnt reaching 0 moves READ -> DRAIN.
REQ-021 fifo_data_i SHALL be written into a 2-entry output buffer on the edge after the cycle in which it is valid; first m_valid_o SHALL rise 2 cycles after the first fifo_rd_en_o.
REQ-022 Throughput: 1 word/cycle sustained while m_ready_i=1 and the FIFO stays non-empty.
REQ-023 m_data_o and m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0; words exit in FIFO order with no loss or duplication.
REQ-024 Each accepted word (m_valid_o & m_ready_i) decrements out_cnt; m_last_o=1 exactly when out_cnt==1.
REQ-025 DRAIN -> DONE when out_cnt reaches 0; DONE asserts done_o for one cycle, then -> IDLE.
REQ-026 A FIFO that goes empty mid-burst SHALL stall issue without error; issue resumes when fifo_empty_i falls.
REQ-027 Simultaneous buffer write and pop in one cycle SHALL keep buf_cnt unchanged and preserve order.
REQ-028 words_left_o = out_cnt; the counter SHALL be 0 in IDLE.

Reset
REQ-029 While rst_i=1, the block SHALL go to IDLE, clear all counters and the buffer, and drive busy_o, done_o, fifo_rd_en_o, m_valid_o, m_last_o = 0 and m_data_o = 0.
REQ-030 Reset during a burst SHALL discard in-flight FIFO data; no word captured before reset is presented after it.

Structure
REQ-031 Shared package syn_fifo_pkg SHALL hold the rd_state_t enum (IDLE, READ, DRAIN, DONE) and the default FIFO_ENTRIES/DATA_WIDTH constants.
REQ-032 The 2-entry output buffer SHALL be a sub-module syn_fifo_skid_buf (DATA_WIDTH+1 bits wide, carrying data and last), with count output.

Verification
REQ-033 Preload 16 words 0x01..0x10, start_i with len=16, m_ready_i=1 -> 16 words out back-to-back in order, m_last_o on 0x10, done_o pulse 1 cycle after last accept, fifo_rd_en_o never asserted while empty.
REQ-034 Preload 8 words, len=8, m_ready_i toggling 1-0-1-0 -> m_data_o stable on stall cycles, 8 words out in order, buffer never exceeds 2.
REQ-035 Preload 2 words, len=5, push 3 more words after 10 cycles -> stall during empty period, then 5 words out, words_left_o goes 5..0.
REQ-036 len=0 start, and start_i pulses during busy -> no rd_en, no done_o, current burst unaffected.
REQ-037 Assert rst_i 3 cycles after first m_valid_o of a len=16 burst -> all outputs 0 the next cycle; a new len=4 burst afterwards outputs only fresh FIFO words.
REQ-038 Full-then-drain: write 16 words until syn_fifo full flag rises, burst len=16 -> full flag falls after first pop, FIFO empty after 16 pops.
